// File: rtl/egress_scheduler_if.sv
// Handshake bundle between the input-port requesters and the egress scheduler.
// The master side drives requests and link/credit status. The slave side returns grants and status.
interface egress_scheduler_if #(
  parameter int NUM_PORTS  = 4,
  parameter int MAX_CREDIT = 8
);
  localparam int CW = $clog2(MAX_CREDIT + 1);

  logic [NUM_PORTS-1:0] req;
  logic                 out_ready;
  logic                 credit_return;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_valid;
  logic [CW-1:0]        credit_cnt;
  logic [NUM_PORTS-1:0] starve_flag;
  logic                 err_credit;

  modport master (
    output req, out_ready, credit_return,
    input  grant, grant_valid, credit_cnt, starve_flag, err_credit
  );

  modport slave (
    input  req, out_ready, credit_return,
    output grant, grant_valid, credit_cnt, starve_flag, err_credit
  );
endinterface

// File: rtl/egress_scheduler.sv
// Credit-based round-robin egress arbiter with starvation override.
// Grants are registered one-hot pulses. A requester granted this cycle is masked out for the next decision.

module egress_wait_ctr #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic granted,
  output logic starved
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [WW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !req || granted) cnt <= '0;
    else if (cnt != WW'(STARVE_LIMIT)) cnt <= cnt + 1'b1;
  end

  assign starved = (cnt == WW'(STARVE_LIMIT));
endmodule

module egress_scheduler #(
  parameter int NUM_PORTS    = 4,
  parameter int MAX_CREDIT   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input logic               clk,
  input logic               rst,
  egress_scheduler_if.slave bus
);
  localparam int CW = $clog2(MAX_CREDIT + 1);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

  state_t               state, state_nxt;
  logic [NUM_PORTS-1:0] grant_q, grant_nxt;
  logic [NUM_PORTS-1:0] eligible, starved;
  logic [PW-1:0]        rr_ptr, rr_nxt, win;
  logic [CW-1:0]        credit_q;
  logic                 err_q;
  logic                 found, has_credit, issue, granting;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wait
    egress_wait_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_wait (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.req[i]),
      .granted (grant_q[i]),
      .starved (starved[i])
    );
  end

  assign granting = (state == GRANT);
  assign eligible = bus.req & ~grant_q;

  // The current grant's credit is consumed at the end of this cycle, so it
  // must be discounted before allowing a back-to-back grant.
  assign has_credit = credit_q > CW'(granting);
  assign issue      = found && has_credit && bus.out_ready;

  // Winner: lowest-index starved requester, else first eligible from rr_ptr.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && eligible[i] && starved[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int off = 0; off < NUM_PORTS; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_PORTS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = '0;
    rr_nxt    = rr_ptr;
    unique case (state)
      IDLE:    if (found) state_nxt = issue ? GRANT : STALL;
      GRANT:   state_nxt = issue ? GRANT : (found ? STALL : IDLE);
      STALL:   state_nxt = issue ? GRANT : (found ? STALL : IDLE);
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      grant_nxt[win] = 1'b1;
      rr_nxt = (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  // A grant consumes its credit at the edge closing its grant cycle, so a
  // credit_return in that same cycle cancels it out.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(MAX_CREDIT);
      err_q    <= 1'b0;
    end else if (bus.credit_return && !granting) begin
      if (credit_q == CW'(MAX_CREDIT)) err_q <= 1'b1;
      else credit_q <= credit_q + 1'b1;
    end else if (granting && !bus.credit_return) begin
      credit_q <= credit_q - 1'b1;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = granting;
  assign bus.credit_cnt  = credit_q;
  assign bus.starve_flag = starved;
  assign bus.err_credit  = err_q;
endmodule

// File: tb/tb_egress_scheduler.sv
// Directed scenarios plus randomized traffic for egress_scheduler.
// All outputs are checked every cycle against a queue-free rule-level reference model.
module tb_egress_scheduler;
  localparam int NP = 4;
  localparam int MC = 8;
  localparam int SL = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  egress_scheduler_if #(.NUM_PORTS(NP), .MAX_CREDIT(MC)) bus ();
  egress_scheduler #(.NUM_PORTS(NP), .MAX_CREDIT(MC), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    tests = 0;
  int    fails = 0;
  string phase = "init";

  // Reference state: index of the port granted this cycle (-1 = none).
  int m_grant, m_rr, m_credit, m_err;
  int m_wait[NP];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = -1; m_rr = 0; m_credit = MC; m_err = 0;
    for (int i = 0; i < NP; i++) m_wait[i] = 0;
  endtask

  task automatic model_step(logic [NP-1:0] r, logic rdy, logic cr, logic rs);
    int pick;
    bit gv;
    if (rs) begin
      model_reset();
      return;
    end
    pick = -1;
    for (int i = 0; i < NP; i++)
      if (pick < 0 && r[i] && i != m_grant && m_wait[i] == SL) pick = i;
    for (int k = 0; k < NP; k++)
      if (pick < 0 && r[(m_rr + k) % NP] && (m_rr + k) % NP != m_grant) pick = (m_rr + k) % NP;
    gv = (m_grant >= 0);
    if (!(rdy && (m_credit - int'(gv)) > 0)) pick = -1;
    if (gv && !cr) m_credit--;
    else if (cr && !gv) begin
      if (m_credit == MC) m_err = 1;
      else m_credit++;
    end
    for (int i = 0; i < NP; i++)
      if (!r[i] || m_grant == i) m_wait[i] = 0;
      else if (m_wait[i] < SL) m_wait[i]++;
    m_grant = pick;
    if (pick >= 0) m_rr = (pick + 1) % NP;
  endtask

  task automatic compare();
    logic [NP-1:0] eg, es;
    eg = '0; es = '0;
    if (m_grant >= 0) eg[m_grant] = 1'b1;
    for (int i = 0; i < NP; i++) es[i] = (m_wait[i] == SL);
    check("grant", 32'(bus.grant), 32'(eg));
    check("grant_valid", 32'(bus.grant_valid), 32'(m_grant >= 0));
    check("credit_cnt", 32'(bus.credit_cnt), 32'(m_credit));
    check("starve_flag", 32'(bus.starve_flag), 32'(es));
    check("err_credit", 32'(bus.err_credit), 32'(m_err));
  endtask

  // One clock: drive, advance model, take the edge, compare 1 time unit later.
  task automatic cyc(logic [NP-1:0] r, logic rdy, logic cr, logic rs);
    bus.req = r; bus.out_ready = rdy; bus.credit_return = cr; rst = rs;
    model_step(r, rdy, cr, rs);
    @(posedge clk); #1;
    compare();
  endtask

  initial begin
    int gcnt;
    bit reached;
    logic [NP-1:0] r;
    rst = 1'b1; bus.req = '0; bus.out_ready = 1'b0; bus.credit_return = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    compare();
    check("rst_credit", 32'(bus.credit_cnt), 32'd8);
    check("rst_grant", 32'(bus.grant), 32'd0);

    phase = "rr";
    cyc(4'b1111, 1'b1, 1'b0, 1'b0);
    check("first", 32'(bus.grant), 32'b0001);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1111, 1'b1, m_grant >= 0, 1'b0);
      check("seq", 32'(bus.grant), 32'(1 << ((k + 1) % 4)));
      check("seq_credit", 32'(bus.credit_cnt), 32'd8);
    end
    cyc(4'b0000, 1'b1, m_grant >= 0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0, 1'b0);

    phase = "mask";
    cyc(4'b0000, 1'b1, 1'b0, 1'b1);
    gcnt = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(4'b0001, 1'b1, 1'b0, 1'b0);
      gcnt += int'(bus.grant[0]);
    end
    check("grants", 32'(gcnt), 32'd8);
    check("empty", 32'(bus.credit_cnt), 32'd0);
    cyc(4'b0001, 1'b1, 1'b1, 1'b0);
    gcnt = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(4'b0001, 1'b1, 1'b0, 1'b0);
      gcnt += int'(bus.grant[0]);
    end
    check("one_more", 32'(gcnt), 32'd1);

    phase = "starve";
    cyc(4'b0000, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      cyc(4'b0110, 1'b0, 1'b0, 1'b0);
      check("flag", 32'(bus.starve_flag), (c >= 16) ? 32'b0110 : 32'd0);
      check("no_grant", 32'(bus.grant), 32'd0);
    end
    cyc(4'b0110, 1'b1, 1'b0, 1'b0);
    check("first_p1", 32'(bus.grant), 32'b0010);
    cyc(4'b0110, 1'b1, 1'b0, 1'b0);
    check("then_p2", 32'(bus.grant), 32'b0100);

    phase = "overflow";
    cyc(4'b0000, 1'b1, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0);
    check("err", 32'(bus.err_credit), 32'd1);
    check("held", 32'(bus.credit_cnt), 32'd8);
    for (int c = 0; c < 10; c++) cyc(4'(c), 1'b1, 1'b0, 1'b0);
    check("sticky", 32'(bus.err_credit), 32'd1);

    phase = "rst_grant";
    cyc(4'b0000, 1'b1, 1'b0, 1'b1);
    cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    check("p2", 32'(bus.grant), 32'b0100);
    cyc(4'b0110, 1'b1, 1'b0, 1'b1);
    check("cleared", 32'(bus.grant), 32'd0);
    check("credit", 32'(bus.credit_cnt), 32'd8);
    cyc(4'b0110, 1'b1, 1'b0, 1'b0);
    check("lowest", 32'(bus.grant), 32'b0010);

    phase = "same_cycle";
    cyc(4'b0000, 1'b1, 1'b0, 1'b1);
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      cyc(4'b1111, 1'b1, 1'b0, 1'b0);
      reached = (m_credit == 3 && m_grant >= 0);
    end
    check("reach3", 32'(reached), 32'd1);
    cyc(4'b1111, 1'b1, 1'b1, 1'b0);
    check("still3", 32'(bus.credit_cnt), 32'd3);

    phase = "random";
    cyc(4'b0000, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      r = 4'($urandom);
      cyc(r, ($urandom % 4) != 0,
          ($urandom % 4 == 0) && (m_credit < MC || $urandom % 8 == 0),
          ($urandom % 60) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/egress_scheduler.md
EGRESS_SCHEDULER -- requirements
Module: egress_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of input-port requesters competing for one output port.
REQ-002 The block SHALL have parameter MAX_CREDIT, default 8, giving the downstream buffer depth in packets.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 16, giving the wait cycles before a requester is flagged starved.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NUM_PORTS bits: bit i is high when input port i's FIFO is non-empty and its head packet targets this output.
REQ-007 The block SHALL have port out_ready, input, 1 bit: the output link accepts a packet this cycle.
REQ-008 The block SHALL have port credit_return, input, 1 bit: a one-cycle pulse meaning the downstream buffer freed one packet slot.
REQ-009 The block SHALL have port grant, output, NUM_PORTS bits: a registered, one-hot pulse; input port i pops its head packet in the cycle grant[i] is high.
REQ-010 The block SHALL have port grant_valid, output, 1 bit: the OR of grant.
REQ-011 The block SHALL have port credit_cnt, output, $clog2(MAX_CREDIT+1) bits: the available downstream credits.
REQ-012 The block SHALL have port starve_flag, output, NUM_PORTS bits: bit i is high while requester i's wait counter equals STARVE_LIMIT.
REQ-013 The block SHALL have port err_credit, output, 1 bit: sticky credit over/underflow error.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT and STALL.
REQ-015 IDLE -> GRANT when an eligible request exists and credit_cnt>0 and out_ready=1; IDLE -> STALL when an eligible request exists and (credit_cnt==0 or out_ready==0).
REQ-016 GRANT is held for one cycle with grant asserted; GRANT -> GRANT for back-to-back grants when another eligible request exists with credit and ready; otherwise GRANT -> STALL or GRANT -> IDLE by the rules of REQ-015.
REQ-017 STALL -> GRANT when the blocking condition clears and an eligible request exists; STALL -> IDLE when no eligible request exists.
REQ-018 Latency: a request sampled at edge N SHALL produce grant high during cycle N+1 at the earliest.
REQ-019 Eligible requests = req with the requester granted in the current cycle masked out, which prevents a double pop before that requester's FIFO empty flag updates.
REQ-020 Selection SHALL be round-robin starting from rr_ptr; after granting port k, rr_ptr = (k+1) mod NUM_PORTS.
REQ-021 Starvation override: if any eligible requester has starve_flag set, the lowest-index starved requester SHALL win, regardless of rr_ptr.
REQ-022 Wait counter i SHALL increment when req[i]=1 and grant[i]=0, saturate at STARVE_LIMIT, and clear on grant[i] or on req[i]=0.
REQ-023 Each grant SHALL decrement credit_cnt by 1 at the same edge; each credit_return SHALL increment it by 1.
REQ-024 A simultaneous grant and credit_return SHALL leave credit_cnt unchanged.
REQ-025 A credit_return when credit_cnt==MAX_CREDIT with no grant in that cycle SHALL hold credit_cnt and set err_credit.
REQ-026 A grant SHALL never issue when credit_cnt==0, so underflow is impossible by construction; err_credit is cleared only by rst.
REQ-027 out_ready=0 SHALL suppress grants only; wait counters keep counting during the stall.
REQ-028 A req[i] that drops while port i is not granted SHALL be ignored with no state change other than clearing wait counter i.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, grant=0, grant_valid=0, rr_ptr=0, credit_cnt=MAX_CREDIT, all wait counters=0, starve_flag=0, err_credit=0.
REQ-030 A reset asserted during GRANT SHALL make grant 0 in the following cycle, with no credit decrement for that edge.
REQ-031 Outputs SHALL be valid and legal from the first cycle after rst deasserts.

Verification
REQ-032 Scenario: after reset, req=4'b1111, out_ready=1, credit_return tied to grant_valid -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and credit_cnt stays 8.
REQ-033 Scenario: req=4'b0001 held high, no credit_return -> grant[0] pulses on alternate cycles (mask rule), 8 grants total, then STALL with credit_cnt=0; one credit_return -> exactly one more grant.
REQ-034 Scenario: out_ready=0 for 20 cycles with req=4'b0110 -> no grant, starve_flag=4'b0110 from cycle 16; on out_ready=1 -> port 1 granted first, then port 2.
REQ-035 Scenario: credit_cnt=8 and credit_return pulsed with no grant -> credit_cnt stays 8 and err_credit=1, which persists until rst.
REQ-036 Scenario: rst asserted in the cycle grant=4'b0100 -> next cycle grant=0, credit_cnt=8, rr_ptr=0; the first grant after release goes to the lowest-index active request.
REQ-037 Scenario: grant and credit_return in the same cycle with credit_cnt=3 -> credit_cnt remains 3.
